// File: rtl/ex_operand_stage.sv
// ex_operand_stage: operand capture, forwarding and load-use detection between decode and EX
module ex_operand_stage (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [3:0]  i_alu_control,
   input  logic [4:0]  i_rs1_addr,
   input  logic [4:0]  i_rs2_addr,
   input  logic [4:0]  i_rd_addr,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   input  logic [31:0] i_imm,
   input  logic        i_use_imm,
   input  logic        i_is_load,
   input  logic        i_reg_write,
   input  logic        i_flush,
   input  logic        i_ex_ready,
   input  logic [4:0]  i_mem_rd_addr,
   input  logic [4:0]  i_wb_rd_addr,
   input  logic        i_mem_reg_write,
   input  logic        i_wb_reg_write,
   input  logic [31:0] i_mem_result,
   input  logic [31:0] i_wb_result,
   output logic        o_valid,
   output logic [3:0]  o_alu_control,
   output logic [31:0] o_a,
   output logic [31:0] o_b,
   output logic [31:0] o_rs2_fwd,
   output logic [4:0]  o_rd_addr,
   output logic        o_reg_write,
   output logic        o_is_load,
   output logic        o_load_use_stall
);
   logic        valid_q, valid_d, use_imm_q, use_imm_d, reg_write_q, reg_write_d, is_load_q, is_load_d;
   logic [3:0]  alu_q, alu_d;
   logic [4:0]  rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_q, rd_d;
   logic [31:0] a_q, a_d, rs2v_q, rs2v_d, imm_q, imm_d;
   logic        accept;
   logic [4:0]  s1_idx, s2_idx;
   logic [31:0] a_fwd, b_fwd;

   // MEM beats WB beats the supplied value; x0 is never forwarded
   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] dflt,
                                       input logic mw, input logic [4:0] ma, input logic [31:0] mr,
                                       input logic ww, input logic [4:0] wa, input logic [31:0] wr);
      return (idx != 5'd0 && mw && ma == idx) ? mr : (idx != 5'd0 && ww && wa == idx) ? wr : dflt;
   endfunction

   assign o_load_use_stall = i_valid & valid_q & is_load_q & reg_write_q & (rd_q != 5'd0) &
                             ((rd_q == i_rs1_addr) | ((rd_q == i_rs2_addr) & !i_use_imm));
   assign o_ready = (!valid_q | i_ex_ready) & !o_load_use_stall;
   assign accept  = i_valid & o_ready & !i_flush;
   // a new capture forwards onto the incoming indices, a held entry refreshes its own
   assign s1_idx  = accept ? i_rs1_addr : rs1_addr_q;
   assign s2_idx  = accept ? i_rs2_addr : rs2_addr_q;
   assign a_fwd   = fwd(s1_idx, accept ? i_rs1_data : a_q, i_mem_reg_write, i_mem_rd_addr, i_mem_result,
                        i_wb_reg_write, i_wb_rd_addr, i_wb_result);
   assign b_fwd   = fwd(s2_idx, accept ? i_rs2_data : rs2v_q, i_mem_reg_write, i_mem_rd_addr, i_mem_result,
                        i_wb_reg_write, i_wb_rd_addr, i_wb_result);

   // next entry: flush kills, accept replaces, stalled hold refreshes operands, otherwise drain
   always_comb begin
      valid_d     = valid_q;
      alu_d       = alu_q;
      a_d         = a_q;
      rs2v_d      = rs2v_q;
      imm_d       = imm_q;
      use_imm_d   = use_imm_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      is_load_d   = is_load_q;
      if (i_flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d     = 1'b1;
         alu_d       = i_alu_control;
         a_d         = a_fwd;
         rs2v_d      = b_fwd;
         imm_d       = i_imm;
         use_imm_d   = i_use_imm;
         rs1_addr_d  = i_rs1_addr;
         rs2_addr_d  = i_rs2_addr;
         rd_d        = i_rd_addr;
         reg_write_d = i_reg_write;
         is_load_d   = i_is_load;
      end else if (valid_q && !i_ex_ready) begin
         a_d    = a_fwd;
         rs2v_d = b_fwd;
      end else begin
         valid_d = 1'b0;
      end
   end

   // entry registers, cleared immediately by reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q     <= 1'b0;
         alu_q       <= 4'd0;
         a_q         <= 32'd0;
         rs2v_q      <= 32'd0;
         imm_q       <= 32'd0;
         use_imm_q   <= 1'b0;
         rs1_addr_q  <= 5'd0;
         rs2_addr_q  <= 5'd0;
         rd_q        <= 5'd0;
         reg_write_q <= 1'b0;
         is_load_q   <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         alu_q       <= alu_d;
         a_q         <= a_d;
         rs2v_q      <= rs2v_d;
         imm_q       <= imm_d;
         use_imm_q   <= use_imm_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         is_load_q   <= is_load_d;
      end
   end

   assign o_valid       = valid_q;
   assign o_alu_control = alu_q;
   assign o_a           = a_q;
   assign o_b           = use_imm_q ? imm_q : rs2v_q;
   assign o_rs2_fwd     = rs2v_q;
   assign o_rd_addr     = rd_q;
   assign o_reg_write   = reg_write_q;
   assign o_is_load     = is_load_q;
endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL expose the following ports.
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  decode presents an instruction.
- o_ready  out  1  stage accepts this cycle.
- i_alu_control  in  4  ALU op code: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 9 SRA.
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  5 each  register indices.
- i_rs1_data, i_rs2_data, i_imm  in  32 each  register-file reads and immediate.
- i_use_imm, i_is_load, i_reg_write  in  1 each  decode flags.
- i_flush  in  1  kill the held entry and the incoming instruction.
- i_ex_ready  in  1  ALU/EX consumer takes o_* this cycle.
- i_mem_rd_addr, i_wb_rd_addr  in  5 each  later-stage destinations.
- i_mem_reg_write, i_wb_reg_write  in  1 each  later-stage write enables.
- i_mem_result, i_wb_result  in  32 each  later-stage write data.
- o_valid  out  1  held entry is valid.
- o_alu_control  out  4  registered op code.
- o_a, o_b  out  32 each  ALU operands.
- o_rs2_fwd  out  32  forwarded rs2, used as store data.
- o_rd_addr  out  5  registered destination.
- o_reg_write, o_is_load  out  1 each  registered flags.
- o_load_use_stall  out  1  load-use hazard indicator.
REQ-002 SHALL use one clock domain; reset asynchronous active-low, as fixed above.

Function
REQ-003 SHALL capture the input on accept = i_valid & o_ready & !i_flush.
REQ-004 SHALL drive o_ready = (!o_valid | i_ex_ready) & !o_load_use_stall.
REQ-005 SHALL assert o_load_use_stall combinationally when all of the following hold:
- i_valid, o_valid, o_is_load, o_reg_write;
- o_rd_addr != 0;
- o_rd_addr == i_rs1_addr, or (o_rd_addr == i_rs2_addr & !i_use_imm).
REQ-006 SHALL, when stalled with i_ex_ready=1, load a bubble: o_valid=0 next cycle, decode holds its inputs.
REQ-007 SHALL resolve each source operand at capture in priority order:
- MEM match (i_mem_reg_write & i_mem_rd_addr == rsX & rsX != 0);
- else WB match (same rule on the WB ports);
- else register-file data.
REQ-008 SHALL never forward for index 0; x0 operand is i_rsX_data unchanged.
REQ-009 SHALL, while o_valid & !i_ex_ready (held), re-apply the REQ-007 match each cycle using the held rs1/rs2 indices and update the held operand on any match.
REQ-010 SHALL drive o_a = held rs1 value; o_b = held imm if held use_imm, else held rs2 value; o_rs2_fwd = held rs2 value regardless of use_imm.
REQ-011 SHALL pass i_alu_control unmodified, codes 10-15 included; no arithmetic is performed here.
REQ-012 SHALL, when o_valid & i_ex_ready & no accept, clear o_valid next cycle.
REQ-013 SHALL give i_flush priority over capture and hold: o_valid=0 next cycle; data registers don't-care.
REQ-014 SHALL, with simultaneous accept and i_ex_ready, replace the entry in the same edge (full throughput, 1 instr/cycle, latency 1 cycle).
REQ-015 SHALL leave o_reg_write and o_is_load qualified by o_valid; consumers ignore them when o_valid=0.

Reset
REQ-016 SHALL, on i_rst_n low, immediately clear:
- o_valid, o_alu_control, o_a, o_b, o_rs2_fwd, o_rd_addr, o_reg_write, o_is_load to 0;
- held rs indices and use_imm to 0.
REQ-017 SHALL drop any instruction in flight when reset is asserted mid-operation; first capture is possible on the first rising edge after i_rst_n rises.

Verification
REQ-018 Scenario: back-to-back ADD (ctrl 0) then SUB (ctrl 8), i_ex_ready=1, rs1_data=5, rs2_data=3 -> one cycle later o_valid=1, o_a=5, o_b=3, o_alu_control=0, then 8 on the next cycle; no bubble.
REQ-019 Scenario: rs1=x7, MEM writes x7=0xAAAA, WB writes x7=0xBBBB in the same cycle -> o_a=0xAAAA; with rs1=x0 and MEM rd=x0 -> o_a=i_rs1_data.
REQ-020 Scenario: held load rd=x4, incoming rs2=x4 with use_imm=0 -> o_load_use_stall=1, o_ready=0, next cycle o_valid=0; with use_imm=1 -> no stall.
REQ-021 Scenario: entry held 3 cycles with i_ex_ready=0, rs2=x9; WB writes x9=0x1234 in cycle 2 -> o_b and o_rs2_fwd read 0x1234 from cycle 3.
REQ-022 Scenario: i_flush=1 together with i_valid=1 and o_valid=1 -> o_valid=0 next cycle, input not captured.
REQ-023 Scenario: i_rst_n pulsed low mid-hold, asynchronous to i_clk -> all outputs 0 before the next edge; capture resumes on the first edge after release.
